// File: rtl/riscv_imem_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// riscv_imem_prefetch_pkg
//   Shared configuration and types for the instruction prefetch buffer.
//   The shared configuration macros are:
//     `XLEN        - machine word width (RV32I: 32)
//     `RV_RESET_PC - default first fetch address after reset
//   Package contents:
//     fetch_entry_t - one buffered {pc, instr} pair
//     ENTRY_W       - width of fetch_entry_t in bits
//     word_align()  - clears address bits [1:0]
// -----------------------------------------------------------------------------
`ifndef RISCV_CONFIGS_DEFINED
`define RISCV_CONFIGS_DEFINED
`define XLEN 32
`define RV_RESET_PC 32'h0000_0000
`endif

package riscv_imem_prefetch_pkg;

   typedef struct packed {
      logic [`XLEN-1:0] pc;
      logic [`XLEN-1:0] instr;
   } fetch_entry_t;

   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

   function automatic logic [`XLEN-1:0] word_align(input logic [`XLEN-1:0] addr);
      return {addr[`XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/riscv_sync_fifo.sv
// -----------------------------------------------------------------------------
// riscv_sync_fifo
//   Single-clock FIFO with a registered storage array and a head read port
//   that shows the oldest entry without popping it.
//   Parameters:
//     WIDTH - entry width in bits
//     DEPTH - number of entries (power of two, >= 2)
//   Ports:
//     clk   in   clock
//     flush in   synchronous clear; wins over push and pop (also used as reset)
//     push  in   write data into the tail
//     data  in   WIDTH  entry written on push
//     pop   in   remove the head entry
//     full  out  count == DEPTH
//     empty out  count == 0
//     count out  occupancy, 0..DEPTH
//     head  out  WIDTH  oldest entry (stale contents when empty)
// -----------------------------------------------------------------------------
module riscv_sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           data,
   input  logic                       pop,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic [WIDTH-1:0]           head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   cnt;
   logic [WIDTH-1:0] mem [DEPTH];

   // Pointers wrap naturally because DEPTH is a power of two.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering in simulation.
   always_ff @(posedge clk) begin
      if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + (PTR_W+1)'(1);
            2'b01:   cnt <= cnt - (PTR_W+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // NOTE: the storage array has no reset; occupancy tracking guarantees an
   // entry is never read before it is written, so clearing it buys nothing.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= data;
   end

   assign head  = mem[rd_ptr];
   assign count = cnt;
   assign full  = (cnt == DEPTH_C);
   assign empty = (cnt == '0);

endmodule

// File: rtl/riscv_imem_prefetch.sv
// -----------------------------------------------------------------------------
// riscv_imem_prefetch
//   Prefetch buffer between the RV32I fetch stage and a synchronous-read
//   instruction memory. Issues sequential word fetches ahead of the core,
//   buffers {pc, instr} pairs and hands them over with valid/ready. A redirect
//   flushes buffered and in-flight words and restarts at the new PC.
//   Configuration macro:
//     PREFETCH_BYPASS_EN - when defined, a response arriving at an empty
//                          buffer is presented combinationally that cycle.
//   Parameters: DEPTH (power of two, >= 2; >= 3 for full throughput), RESET_PC
//   Ports:
//     i_clk, i_rst          clock, synchronous active-high reset
//     o_imem_req/addr       fetch request and word-aligned address
//     i_imem_gnt            memory accepts the request this cycle
//     i_imem_rd_data        read data, one cycle after acceptance
//     o_fetch_valid/pc/instr head entry presented to the core
//     i_fetch_ready         core consumes the head entry
//     i_redirect/_pc        flush and restart fetch at i_redirect_pc
// -----------------------------------------------------------------------------
module riscv_imem_prefetch
   import riscv_imem_prefetch_pkg::*;
#(
   parameter int unsigned       DEPTH    = 4,
   parameter logic [`XLEN-1:0]  RESET_PC = `RV_RESET_PC
) (
   input  logic               i_clk,
   input  logic               i_rst,
   output logic               o_imem_req,
   output logic [`XLEN-1:0]   o_imem_addr,
   input  logic               i_imem_gnt,
   input  logic [`XLEN-1:0]   i_imem_rd_data,
   output logic               o_fetch_valid,
   output logic [`XLEN-1:0]   o_fetch_pc,
   output logic [`XLEN-1:0]   o_fetch_instr,
   input  logic               i_fetch_ready,
   input  logic               i_redirect,
   input  logic [`XLEN-1:0]   i_redirect_pc
);

   localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

   logic [`XLEN-1:0] fa;          // next fetch address
   logic [`XLEN-1:0] rsp_pc;      // address of the word currently in flight
   logic             inf;         // a response arrives this cycle
   fetch_entry_t     last;        // last presented entry, shown while empty

   logic             kill;
   logic             accept;
   logic             rsp_arrive;
   logic [CNT_W:0]   occ;
   logic             push;
   logic             pop;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;
   fetch_entry_t     shown;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   // Reset behaves as a redirect to RESET_PC plus an output clear.
   assign kill       = i_rst | i_redirect;

   // Buffered plus in-flight words bound the outstanding requests, so a
   // response always has a free slot to land in.
   assign occ         = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inf};
   assign o_imem_req  = !kill && (occ < DEPTH_C);
   assign o_imem_addr = fa;
   assign accept      = o_imem_req & i_imem_gnt;

   // A response landing in a redirect/reset cycle belongs to the old stream.
   assign rsp_arrive  = inf & !kill;
   assign push_entry  = '{pc: rsp_pc, instr: i_imem_rd_data};
   assign pop         = !fifo_empty & i_fetch_ready & !kill;

`ifdef PREFETCH_BYPASS_EN
   logic bypass_hit;
   assign bypass_hit    = fifo_empty & rsp_arrive;
   assign o_fetch_valid = !fifo_empty | bypass_hit;
   assign shown         = !fifo_empty ? head : (bypass_hit ? push_entry : last);
   // A bypassed word the core takes immediately is never stored.
   assign push          = rsp_arrive & !(bypass_hit & i_fetch_ready);
`else
   assign o_fetch_valid = !fifo_empty;
   assign shown         = !fifo_empty ? head : last;
   assign push          = rsp_arrive;
`endif

   assign o_fetch_pc    = shown.pc;
   assign o_fetch_instr = shown.instr;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fa     <= RESET_PC;
         rsp_pc <= '0;
         inf    <= 1'b0;
         last   <= '0;
      end else begin
         if (i_redirect)  fa <= word_align(i_redirect_pc);
         else if (accept) fa <= fa + `XLEN'(4);
         if (accept)      rsp_pc <= fa;
         inf <= accept;
         if (o_fetch_valid) last <= shown;
      end
   end

   riscv_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .flush (kill),
      .push  (push),
      .data  (push_entry),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .head  (head)
   );

   // The occupancy bound on requests makes push-on-full impossible.
   a_no_push_on_full: assert property (@(posedge i_clk) disable iff (i_rst)
      !(push && fifo_full));

endmodule

// File: tb/tb_riscv_imem_prefetch.sv
// -----------------------------------------------------------------------------
// tb_riscv_imem_prefetch
//   Scoreboard bench: every granted request pushes its expected {pc, instr}
//   into a queue; a monitor pops and compares each word the DUT hands over.
//   Memory words are address-tagged (addr ^ MEM_KEY) so pc/instr mix-ups show.
// -----------------------------------------------------------------------------
module tb_riscv_imem_prefetch;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] MEM_KEY  = 32'hC0DE_0000;
`ifdef PREFETCH_BYPASS_EN
   localparam int FIRST_LAT = 1;
`else
   localparam int FIRST_LAT = 2;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic [31:0] i_imem_rd_data = 32'hBAD0_BAD0;
   logic        o_fetch_valid;
   logic [31:0] o_fetch_pc;
   logic [31:0] o_fetch_instr;
   logic        i_fetch_ready;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;

   always #5 i_clk = ~i_clk;

   riscv_imem_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .o_imem_req     (o_imem_req),
      .o_imem_addr    (o_imem_addr),
      .i_imem_gnt     (i_imem_gnt),
      .i_imem_rd_data (i_imem_rd_data),
      .o_fetch_valid  (o_fetch_valid),
      .o_fetch_pc     (o_fetch_pc),
      .o_fetch_instr  (o_fetch_instr),
      .i_fetch_ready  (i_fetch_ready),
      .i_redirect     (i_redirect),
      .i_redirect_pc  (i_redirect_pc)
   );

   // Synchronous-read memory: data one cycle after an accepted request.
   always @(posedge i_clk)
      i_imem_rd_data <= (o_imem_req && i_imem_gnt) ? (o_imem_addr ^ MEM_KEY) : 32'hBAD0_BAD0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   int          vectors     = 0;
   int          miscompares = 0;
   int          pops        = 0;
   int          accepts     = 0;
   exp_t        exp_q[$];
   logic [31:0] exp_fa      = RESET_PC;
   logic [31:0] last_pc     = 32'h0;
   logic [31:0] last_instr  = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, want, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Request model and output monitor, evaluated mid-cycle for the coming edge.
   always @(negedge i_clk) begin
      exp_t e;
      if (i_rst) begin
         exp_q.delete();
         exp_fa = RESET_PC;
      end else if (i_redirect) begin
         check("req_in_redirect", {31'b0, o_imem_req}, 32'd0);
         exp_q.delete();
         exp_fa = i_redirect_pc & ~32'h3;
      end else begin
         if (o_fetch_valid && i_fetch_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_fetch: got pc 0x%08h, expected no output at %0t",
                        o_fetch_pc, $time);
            end else begin
               e = exp_q.pop_front();
               check("fetch_pc", o_fetch_pc, e.pc);
               check("fetch_instr", o_fetch_instr, e.instr);
               last_pc    = e.pc;
               last_instr = e.instr;
               pops++;
            end
         end
         if (o_imem_req) begin
            check("imem_addr", o_imem_addr, exp_fa);
            if (i_imem_gnt) begin
               exp_q.push_back('{pc: exp_fa, instr: exp_fa ^ MEM_KEY});
               exp_fa  = exp_fa + 32'd4;
               accepts++;
            end
         end
      end
   end

   // Directed gnt pattern for the stall test.
   logic gnt_pat [11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      int          p0;
      logic [31:0] hold_pc;
      logic [31:0] hold_instr;

      i_rst = 1'b1; i_imem_gnt = 1'b0; i_fetch_ready = 1'b0;
      i_redirect = 1'b0; i_redirect_pc = 32'h0;
      repeat (3) tick();

      // Reset state
      @(negedge i_clk);
      check("rst_req",   {31'b0, o_imem_req},    32'd0);
      check("rst_addr",  o_imem_addr,            RESET_PC);
      check("rst_valid", {31'b0, o_fetch_valid}, 32'd0);
      check("rst_pc",    o_fetch_pc,             32'd0);
      check("rst_instr", o_fetch_instr,          32'd0);

      // Release: first request in the first cycle, first valid after FIRST_LAT
      tick();
      i_rst = 1'b0; i_imem_gnt = 1'b1; i_fetch_ready = 1'b1;
      @(negedge i_clk);
      check("first_req",    {31'b0, o_imem_req},    32'd1);
      check("first_valid0", {31'b0, o_fetch_valid}, 32'd0);
      for (int c = 1; c <= FIRST_LAT; c++) begin
         tick();
         @(negedge i_clk);
         check("first_valid_lat", {31'b0, o_fetch_valid}, (c == FIRST_LAT) ? 32'd1 : 32'd0);
      end
      check("first_pc", o_fetch_pc, RESET_PC);

      // Steady-state throughput: one word per cycle
      tick();
      p0 = pops;
      repeat (20) tick();
      check("throughput", 32'(pops - p0), 32'd20);

      // Core stalls: requests stop once buffered + in flight reaches DEPTH
      i_fetch_ready = 1'b0;
      repeat (10) tick();
      check("stall_outstanding", 32'(accepts - pops), DEPTH);
      @(negedge i_clk);
      check("stall_req_drop", {31'b0, o_imem_req},    32'd0);
      check("stall_valid",    {31'b0, o_fetch_valid}, 32'd1);
      tick();
      i_fetch_ready = 1'b1;
      repeat (12) tick();

      // Redirect with 3 buffered entries and one in flight
      i_fetch_ready = 1'b0;
      tick();
      tick();
      check("pre_redirect_outstanding", 32'(accepts - pops), 32'd4);
      i_redirect = 1'b1; i_redirect_pc = 32'h0000_0103;
      tick();
      i_redirect = 1'b0; i_fetch_ready = 1'b1;
      @(negedge i_clk);
      check("redir_req",    {31'b0, o_imem_req},    32'd1);
      check("redir_addr",   o_imem_addr,            32'h0000_0100);
      check("redir_valid0", {31'b0, o_fetch_valid}, 32'd0);
      for (int c = 1; c <= FIRST_LAT; c++) begin
         tick();
         @(negedge i_clk);
         check("redir_valid_lat", {31'b0, o_fetch_valid}, (c == FIRST_LAT) ? 32'd1 : 32'd0);
      end
      check("redir_first_pc", o_fetch_pc, 32'h0000_0100);
      repeat (6) tick();

      // Ungranted request dropped by back-to-back redirects; the last one wins
      i_imem_gnt = 1'b0;
      repeat (3) tick();
      i_redirect = 1'b1; i_redirect_pc = 32'h0000_0200;
      tick();
      i_redirect_pc = 32'h0000_0306;
      tick();
      i_redirect = 1'b0; i_imem_gnt = 1'b1;
      @(negedge i_clk);
      check("b2b_redir_addr", o_imem_addr, 32'h0000_0304);
      repeat (8) tick();

      // Grant toggling: address must hold during the 0s, nothing skipped
      foreach (gnt_pat[i]) begin
         i_imem_gnt = gnt_pat[i];
         tick();
      end
      i_imem_gnt = 1'b1;
      repeat (6) tick();

      // Reset pulse while full
      i_fetch_ready = 1'b0;
      repeat (8) tick();
      i_rst = 1'b1;
      tick();
      @(negedge i_clk);
      check("midrst_req",   {31'b0, o_imem_req},    32'd0);
      check("midrst_addr",  o_imem_addr,            RESET_PC);
      check("midrst_valid", {31'b0, o_fetch_valid}, 32'd0);
      check("midrst_pc",    o_fetch_pc,             32'd0);
      check("midrst_instr", o_fetch_instr,          32'd0);
      tick();
      i_rst = 1'b0; i_fetch_ready = 1'b1;
      @(negedge i_clk);
      check("resume_addr", o_imem_addr, RESET_PC);
      repeat (8) tick();

      // Address wrap past 0xFFFF_FFFC
      i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFF4;
      tick();
      i_redirect = 1'b0;
      repeat (3) tick();
      @(negedge i_clk);
      check("wrap_addr", o_imem_addr, 32'h0000_0000);
      repeat (8) tick();

      // Drain to empty: outputs hold the last presented entry
      i_imem_gnt = 1'b0;
      repeat (6) tick();
      hold_pc    = last_pc;
      hold_instr = last_instr;
      @(negedge i_clk);
      check("empty_valid",      {31'b0, o_fetch_valid}, 32'd0);
      check("empty_hold_pc",    o_fetch_pc,             hold_pc);
      check("empty_hold_instr", o_fetch_instr,          hold_instr);
      tick();
      check("drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
